// File: rtl/dbg_spi_host.sv
// SPI mode-0, MSB-first host for the debug command protocol. Each transaction sends one opcode,
// plus the ECHO argument when present, and collects the reply right-aligned into rsp_data.
module dbg_spi_host #(
  parameter int CLK_DIV    = 8,
  parameter int GAP_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_op,
  input  logic [7:0]  cmd_arg,
  output logic        rsp_valid,
  output logic [3:0]  rsp_len,
  output logic [63:0] rsp_data,
  output logic        busy,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        ss_n
);

  // state   | meaning
  // IDLE    | ss_n high, cmd_ready high, waiting for cmd_valid
  // SETUP   | ss_n low, CLK_DIV cycles before the first SCLK rise
  // SHIFT   | clocking the 8 bits of the current byte
  // GAP     | GAP_CYCLES between bytes, SCLK low, ss_n low
  // HOLD    | CLK_DIV cycles after the last bit before releasing ss_n
  // RECOVER | ss_n high for CLK_DIV cycles before the next command
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_SHIFT   = 3'd2;
  localparam logic [2:0] S_GAP     = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;
  localparam logic [2:0] S_RECOVER = 3'd5;

  localparam logic [7:0] OP_ECHO     = 8'h01;
  localparam logic [7:0] OP_GET_PC   = 8'h06;
  localparam logic [7:0] OP_GET_INSN = 8'h07;

  localparam int HW = $clog2(CLK_DIV) + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [HW-1:0] HP_LOAD  = HW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HP_ONE   = HW'(1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  logic [2:0]    state_q,    state_d;
  logic [HW-1:0] hp_cnt_q,   hp_cnt_d;
  logic [GW-1:0] gap_cnt_q,  gap_cnt_d;
  logic [2:0]    bit_cnt_q,  bit_cnt_d;
  logic [3:0]    byte_cnt_q, byte_cnt_d;
  logic [3:0]    last_q,     last_d;
  logic [7:0]    op_q,       op_d;
  logic [7:0]    arg_q,      arg_d;
  logic [6:0]    rx_q,       rx_d;
  logic [63:0]   rsp_data_q, rsp_data_d;
  logic [3:0]    rsp_len_q,  rsp_len_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          sclk_q,     sclk_d;
  logic          mosi_q,     mosi_d;
  logic          ss_n_q,     ss_n_d;
  logic          miso_s1_q,  miso_s2_q;

  logic [7:0] cur_byte;
  logic [7:0] nxt_byte;
  logic [7:0] rx_byte;
  logic       keep;

  function automatic logic [7:0] tx_byte(input logic [7:0] op, input logic [7:0] arg,
                                         input logic [3:0] idx);
    logic [7:0] b;
    b = 8'h00;
    if (idx == 4'd0) b = op;
    else if (op == OP_ECHO && idx == 4'd1) b = arg;
    return b;
  endfunction

  function automatic logic [3:0] last_idx(input logic [7:0] op);
    logic [3:0] n;
    case (op)
      OP_GET_PC:   n = 4'd9;
      OP_GET_INSN: n = 4'd5;
      OP_ECHO:     n = 4'd2;
      default:     n = 4'd0;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] reply_len(input logic [7:0] op);
    logic [3:0] n;
    case (op)
      OP_GET_PC:   n = 4'd8;
      OP_GET_INSN: n = 4'd4;
      OP_ECHO:     n = 4'd1;
      default:     n = 4'd0;
    endcase
    return n;
  endfunction

  always_comb begin
    cur_byte = tx_byte(op_q, arg_q, byte_cnt_q);
    nxt_byte = tx_byte(op_q, arg_q, byte_cnt_q + 4'd1);
    rx_byte  = {rx_q, miso_s2_q};
    keep     = 1'b0;
    // The first two reply bytes of a GET are the slave's opcode turnaround, not data.
    if ((op_q == OP_GET_PC || op_q == OP_GET_INSN) && byte_cnt_q >= 4'd2) keep = 1'b1;
    if (op_q == OP_ECHO && byte_cnt_q == 4'd2) keep = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    hp_cnt_d    = hp_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    last_d      = last_q;
    op_d        = op_q;
    arg_d       = arg_q;
    rx_d        = rx_q;
    rsp_data_d  = rsp_data_q;
    rsp_len_d   = rsp_len_q;
    rsp_valid_d = 1'b0;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    ss_n_d      = ss_n_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d       = cmd_op;
          arg_d      = cmd_arg;
          last_d     = last_idx(cmd_op);
          byte_cnt_d = 4'd0;
          bit_cnt_d  = 3'd7;
          hp_cnt_d   = HP_LOAD;
          rsp_data_d = 64'h0;
          rsp_len_d  = 4'd0;
          mosi_d     = cmd_op[7];
          ss_n_d     = 1'b0;
          state_d    = S_SETUP;
        end
      end

      S_SETUP: begin
        if (hp_cnt_q != '0) begin
          hp_cnt_d = hp_cnt_q - HP_ONE;
        end else begin
          hp_cnt_d = HP_LOAD;
          mosi_d   = cur_byte[7];
          state_d  = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (hp_cnt_q != '0) begin
          hp_cnt_d = hp_cnt_q - HP_ONE;
        end else begin
          hp_cnt_d = HP_LOAD;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Last cycle of the high phase: sample, drop SCLK, move to the next bit.
            sclk_d = 1'b0;
            rx_d   = rx_byte[6:0];
            if (bit_cnt_q != 3'd0) begin
              bit_cnt_d = bit_cnt_q - 3'd1;
              mosi_d    = cur_byte[bit_cnt_q - 3'd1];
            end else begin
              bit_cnt_d = 3'd7;
              if (keep) rsp_data_d = {rsp_data_q[55:0], rx_byte};
              if (byte_cnt_q == last_q) begin
                mosi_d  = 1'b0;
                state_d = S_HOLD;
              end else begin
                byte_cnt_d = byte_cnt_q + 4'd1;
                gap_cnt_d  = GAP_LOAD;
                mosi_d     = nxt_byte[7];
                state_d    = S_GAP;
              end
            end
          end
        end
      end

      S_GAP: begin
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end else begin
          hp_cnt_d = HP_LOAD;
          mosi_d   = cur_byte[7];
          state_d  = S_SHIFT;
        end
      end

      S_HOLD: begin
        if (hp_cnt_q != '0) begin
          hp_cnt_d = hp_cnt_q - HP_ONE;
        end else begin
          hp_cnt_d    = HP_LOAD;
          ss_n_d      = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_len_d   = reply_len(op_q);
          state_d     = S_RECOVER;
        end
      end

      S_RECOVER: begin
        if (hp_cnt_q != '0) hp_cnt_d = hp_cnt_q - HP_ONE;
        else state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        sclk_d  = 1'b0;
        ss_n_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hp_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      bit_cnt_q   <= 3'd7;
      byte_cnt_q  <= 4'd0;
      last_q      <= 4'd0;
      op_q        <= 8'h00;
      arg_q       <= 8'h00;
      rx_q        <= 7'h00;
      rsp_data_q  <= 64'h0;
      rsp_len_q   <= 4'd0;
      rsp_valid_q <= 1'b0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      ss_n_q      <= 1'b1;
      miso_s1_q   <= 1'b0;
      miso_s2_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hp_cnt_q    <= hp_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      last_q      <= last_d;
      op_q        <= op_d;
      arg_q       <= arg_d;
      rx_q        <= rx_d;
      rsp_data_q  <= rsp_data_d;
      rsp_len_q   <= rsp_len_d;
      rsp_valid_q <= rsp_valid_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      ss_n_q      <= ss_n_d;
      miso_s1_q   <= miso;
      miso_s2_q   <= miso_s1_q;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = ~cmd_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_len   = rsp_len_q;
  assign rsp_data  = rsp_data_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign ss_n      = ss_n_q;

endmodule
